// File: rtl/ctrl_pkg.sv
// -----------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the hardwired control unit of the single-bus datapath:
//   - instruction opcodes and IR field bit positions
//   - 4-bit state encoding and the matching state enum
//   - bit indices of the one-hot alu_op select
//   - opcode class enum produced by ctrl_decode
//   - packed struct of the single-bit control strobes
// -----------------------------------------------------------------------------
package ctrl_pkg;

  // Opcodes (IR[31:27])
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // IR field positions
  localparam int IR_OP_MSB = 31;
  localparam int IR_OP_LSB = 27;
  localparam int IR_RA_MSB = 26;
  localparam int IR_RA_LSB = 23;
  localparam int IR_RB_MSB = 22;
  localparam int IR_RB_LSB = 19;
  localparam int IR_RC_MSB = 18;
  localparam int IR_RC_LSB = 15;

  // State encoding
  localparam logic [3:0] ST_IDLE = 4'd0;
  localparam logic [3:0] ST_T0   = 4'd1;
  localparam logic [3:0] ST_T1   = 4'd2;
  localparam logic [3:0] ST_T2   = 4'd3;
  localparam logic [3:0] ST_T3   = 4'd4;
  localparam logic [3:0] ST_T4   = 4'd5;
  localparam logic [3:0] ST_T5   = 4'd6;
  localparam logic [3:0] ST_T6   = 4'd7;
  localparam logic [3:0] ST_HALT = 4'd8;

  typedef enum logic [3:0] {
    S_IDLE = ST_IDLE,
    S_T0   = ST_T0,
    S_T1   = ST_T1,
    S_T2   = ST_T2,
    S_T3   = ST_T3,
    S_T4   = ST_T4,
    S_T5   = ST_T5,
    S_T6   = ST_T6,
    S_HALT = ST_HALT
  } state_e;

  // alu_op one-hot bit indices
  localparam int ALU_W    = 13;
  localparam int ALU_AND  = 0;
  localparam int ALU_OR   = 1;
  localparam int ALU_ADD  = 2;
  localparam int ALU_SUB  = 3;
  localparam int ALU_MUL  = 4;
  localparam int ALU_DIV  = 5;
  localparam int ALU_SHR  = 6;
  localparam int ALU_SHRA = 7;
  localparam int ALU_SHL  = 8;
  localparam int ALU_ROR  = 9;
  localparam int ALU_ROL  = 10;
  localparam int ALU_NEG  = 11;
  localparam int ALU_NOT  = 12;

  typedef enum logic [2:0] {
    CLS_ALU3,
    CLS_MULDIV,
    CLS_UNARY,
    CLS_NOP,
    CLS_HALT,
    CLS_ILLEGAL
  } op_class_e;

  // Single-bit bus drives and register loads
  typedef struct packed {
    logic pc_out;
    logic mdr_out;
    logic zhigh_out;
    logic zlow_out;
    logic pc_in;
    logic ir_in;
    logic mar_in;
    logic mdr_in;
    logic y_in;
    logic z_in;
    logic hi_in;
    logic lo_in;
    logic read;
    logic inc_pc;
  } strobes_t;

endpackage

// File: rtl/control_unit_if.sv
// -----------------------------------------------------------------------------
// control_unit_if
// Bundle between the control unit and the datapath/memory side.
//   master (control_unit): takes run, mem_wait, IR; drives every strobe,
//                          alu_op, halted and ill.
//   slave  (datapath)    : the mirror image.
// -----------------------------------------------------------------------------
interface control_unit_if;

  logic                        run;
  logic                        mem_wait;
  logic [31:0]                 IR;

  logic [15:0]                 reg_out;
  logic [15:0]                 reg_in;
  logic                        PCout;
  logic                        MDRout;
  logic                        Zhighout;
  logic                        Zlowout;
  logic                        PCin;
  logic                        IRin;
  logic                        MARin;
  logic                        MDRin;
  logic                        Yin;
  logic                        Zin;
  logic                        HIin;
  logic                        LOin;
  logic                        Read;
  logic                        IncPC;
  logic [ctrl_pkg::ALU_W-1:0]  alu_op;
  logic                        halted;
  logic                        ill;

  modport master (
    input  run, mem_wait, IR,
    output reg_out, reg_in, PCout, MDRout, Zhighout, Zlowout,
           PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin,
           Read, IncPC, alu_op, halted, ill
  );

  modport slave (
    output run, mem_wait, IR,
    input  reg_out, reg_in, PCout, MDRout, Zhighout, Zlowout,
           PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin,
           Read, IncPC, alu_op, halted, ill
  );

endinterface

// File: rtl/ctrl_decode.sv
// -----------------------------------------------------------------------------
// ctrl_decode
// Combinational opcode decoder.
//   op       in  5 : IR opcode field
//   op_class out   : alu3 / muldiv / unary / nop / halt / illegal
//   alu_sel  out 13: one-hot ALU select for the opcode (0 when not an ALU op)
//   ill      out 1 : opcode is illegal in this build
// Build option: CTRL_MULDIV_EN -- when undefined, mul/div decode as illegal.
// -----------------------------------------------------------------------------
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [4:0]       op,
  output op_class_e        op_class,
  output logic [ALU_W-1:0] alu_sel,
  output logic             ill
);

  always_comb begin
    // NOTE: every output gets a value before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    op_class = CLS_ILLEGAL;
    alu_sel  = '0;
    case (op)
      OP_ADD:  begin op_class = CLS_ALU3;  alu_sel[ALU_ADD]  = 1'b1; end
      OP_SUB:  begin op_class = CLS_ALU3;  alu_sel[ALU_SUB]  = 1'b1; end
      OP_AND:  begin op_class = CLS_ALU3;  alu_sel[ALU_AND]  = 1'b1; end
      OP_OR:   begin op_class = CLS_ALU3;  alu_sel[ALU_OR]   = 1'b1; end
      OP_ROR:  begin op_class = CLS_ALU3;  alu_sel[ALU_ROR]  = 1'b1; end
      OP_ROL:  begin op_class = CLS_ALU3;  alu_sel[ALU_ROL]  = 1'b1; end
      OP_SHR:  begin op_class = CLS_ALU3;  alu_sel[ALU_SHR]  = 1'b1; end
      OP_SHRA: begin op_class = CLS_ALU3;  alu_sel[ALU_SHRA] = 1'b1; end
      OP_SHL:  begin op_class = CLS_ALU3;  alu_sel[ALU_SHL]  = 1'b1; end
`ifdef CTRL_MULDIV_EN
      OP_MUL:  begin op_class = CLS_MULDIV; alu_sel[ALU_MUL] = 1'b1; end
      OP_DIV:  begin op_class = CLS_MULDIV; alu_sel[ALU_DIV] = 1'b1; end
`endif
      OP_NEG:  begin op_class = CLS_UNARY; alu_sel[ALU_NEG]  = 1'b1; end
      OP_NOT:  begin op_class = CLS_UNARY; alu_sel[ALU_NOT]  = 1'b1; end
      OP_NOP:  op_class = CLS_NOP;
      OP_HALT: op_class = CLS_HALT;
      default: ;
    endcase
    ill = (op_class == CLS_ILLEGAL);
  end

endmodule

// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit
// Hardwired Moore sequencer for the single-bus datapath. Fetches (T0-T2),
// decodes IR and walks the T-states for each instruction class.
//   clk   in : single clock, rising edge
//   reset in : synchronous, active-high; returns to IDLE
//   bus      : control_unit_if.master -- run, mem_wait, IR in; register
//              drives/loads, PC/MDR/Z/HI/LO strobes, Read, IncPC, alu_op,
//              halted and ill out
// Outputs are a combinational decode of the registered state plus IR, so
// they hold for the whole state cycle.
// Build option: CTRL_MULDIV_EN -- enables the mul/div T3..T6 sequence; when
// undefined T6 is unreachable and HIin/LOin/Zhighout stay 0.
// -----------------------------------------------------------------------------
module control_unit
  import ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  control_unit_if.master bus
);

  state_e           state_q, state_d;

  logic [4:0]       op;
  logic [3:0]       ra, rb, rc;
  op_class_e        op_class;
  logic [ALU_W-1:0] alu_sel;
  logic             dec_ill;

  strobes_t         st;
  logic             out_en, in_en, alu_en;
  logic [3:0]       out_idx;

  // Low IR bits carry immediates/unused fields for this sequencer.
  logic             unused_ir_bits;
  assign unused_ir_bits = ^bus.IR[IR_RC_LSB-1:0];

  assign op = bus.IR[IR_OP_MSB:IR_OP_LSB];
  assign ra = bus.IR[IR_RA_MSB:IR_RA_LSB];
  assign rb = bus.IR[IR_RB_MSB:IR_RB_LSB];
  assign rc = bus.IR[IR_RC_MSB:IR_RC_LSB];

  ctrl_decode u_decode (
    .op       (op),
    .op_class (op_class),
    .alu_sel  (alu_sel),
    .ill      (dec_ill)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.run) state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1:   if (!bus.mem_wait) state_d = S_T2;
      S_T2:   state_d = S_T3;
      S_T3: begin
        case (op_class)
          CLS_HALT:             state_d = S_HALT;
          CLS_NOP, CLS_ILLEGAL: state_d = S_T0;
          default:              state_d = S_T4;
        endcase
      end
      S_T4:   state_d = (op_class == CLS_UNARY) ? S_T0 : S_T5;
`ifdef CTRL_MULDIV_EN
      S_T5:   state_d = (op_class == CLS_MULDIV) ? S_T6 : S_T0;
      S_T6:   state_d = S_T0;
`else
      S_T5:   state_d = S_T0;
`endif
      S_HALT: state_d = S_HALT;   // only reset leaves HALT
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its input from before the edge.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Output decode. A single register-bus source index and a single
  // destination (always ra) feed shared 4-to-16 decoders, which keeps
  // reg_out and reg_in one-hot or zero by construction.
  // ---------------------------------------------------------------------------
  always_comb begin
    st      = '0;
    out_en  = 1'b0;
    out_idx = rb;
    in_en   = 1'b0;
    alu_en  = 1'b0;
    case (state_q)
      S_T0: begin
        st.pc_out = 1'b1;
        st.mar_in = 1'b1;
        st.inc_pc = 1'b1;
        st.pc_in  = 1'b1;
      end
      S_T1: begin
        st.read   = 1'b1;
        st.mdr_in = 1'b1;
      end
      S_T2: begin
        st.mdr_out = 1'b1;
        st.ir_in   = 1'b1;
      end
      S_T3: begin
        case (op_class)
          CLS_ALU3:   begin out_en = 1'b1; out_idx = rb; st.y_in = 1'b1; end
          CLS_MULDIV: begin out_en = 1'b1; out_idx = ra; st.y_in = 1'b1; end
          CLS_UNARY: begin
            out_en  = 1'b1;
            out_idx = rb;
            alu_en  = 1'b1;
            st.z_in = 1'b1;
          end
          default: ;
        endcase
      end
      S_T4: begin
        case (op_class)
          CLS_ALU3: begin
            out_en  = 1'b1;
            out_idx = rc;
            alu_en  = 1'b1;
            st.z_in = 1'b1;
          end
          CLS_MULDIV: begin
            out_en  = 1'b1;
            out_idx = rb;
            alu_en  = 1'b1;
            st.z_in = 1'b1;
          end
          CLS_UNARY: begin st.zlow_out = 1'b1; in_en = 1'b1; end
          default: ;
        endcase
      end
      S_T5: begin
        case (op_class)
          CLS_ALU3: begin st.zlow_out = 1'b1; in_en = 1'b1; end
`ifdef CTRL_MULDIV_EN
          CLS_MULDIV: begin st.zlow_out = 1'b1; st.lo_in = 1'b1; end
`endif
          default: ;
        endcase
      end
`ifdef CTRL_MULDIV_EN
      S_T6: begin
        st.zhigh_out = 1'b1;
        st.hi_in     = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign bus.reg_out  = out_en ? (16'd1 << out_idx) : 16'd0;
  assign bus.reg_in   = in_en  ? (16'd1 << ra)      : 16'd0;
  assign bus.alu_op   = alu_en ? alu_sel : '0;

  assign bus.PCout    = st.pc_out;
  assign bus.MDRout   = st.mdr_out;
  assign bus.Zhighout = st.zhigh_out;
  assign bus.Zlowout  = st.zlow_out;
  assign bus.PCin     = st.pc_in;
  assign bus.IRin     = st.ir_in;
  assign bus.MARin    = st.mar_in;
  assign bus.MDRin    = st.mdr_in;
  assign bus.Yin      = st.y_in;
  assign bus.Zin      = st.z_in;
  assign bus.HIin     = st.hi_in;
  assign bus.LOin     = st.lo_in;
  assign bus.Read     = st.read;
  assign bus.IncPC    = st.inc_pc;

  assign bus.halted   = (state_q == S_HALT);
  assign bus.ill      = dec_ill && (state_q == S_T3);

endmodule

// File: doc/control_unit.md
# control_unit

Hardwired Moore sequencer that drives the single-bus datapath's control strobes. It fetches each instruction from memory, decodes the IR, and sequences register, ALU, Z, HI and LO transfers through the T-states. It replaces the hand-written state walks in the datapath benches. It sits beside `datapath`, takes the IR contents back from it, and owns every `*in`, `*out`, ALU-select, `Read` and `IncPC` line.

## Interface
- No parameters. Opcode values and state encodings come from the package.
- `clk` in 1: single clock. All state changes occur on the rising edge.
- `reset` in 1: synchronous, active-high.
- `run` in 1: starts fetching from IDLE.
- `mem_wait` in 1: memory not ready. Holds the block in T1.
- `IR` in 32: IR register contents, with these fields:
  - `op` = [31:27]
  - `ra` = [26:23]
  - `rb` = [22:19]
  - `rc` = [18:15]
- `reg_out` out 16: one-hot register-file bus drive, mapped to `R0out`..`R15out`.
- `reg_in` out 16: one-hot register-file load, mapped to `R0in`..`R15in`.
- `PCout`, `MDRout`, `Zhighout`, `Zlowout` out 1 each: bus drives.
- `PCin`, `IRin`, `MARin`, `MDRin`, `Yin`, `Zin`, `HIin`, `LOin` out 1 each: register loads.
- `Read`, `IncPC` out 1 each: memory read and PC increment.
- `alu_op` out 13: one-hot ALU select. Bit order [12:0] is NOT, NEG, ROL, ROR, SHL, SHRA, SHR, DIV, MUL, SUB, ADD, OR, AND.
- `halted` out 1: high while in HALT.
- `ill` out 1: one-cycle illegal-opcode pulse.

## Operation
- **States:** IDLE, T0, T1, T2, T3, T4, T5, T6, HALT.
- **Opcodes:**
  - add 00011, sub 00100, and 00101, or 00110
  - ror 00111, rol 01000, shr 01001, shra 01010, shl 01011
  - div 01111, mul 10000, neg 10001, not 10010
  - nop 11010, halt 11011
  - All other opcodes are illegal.
- **IDLE:** all outputs 0. Moves to T0 when `run`=1.
- **T0:** `PCout`, `MARin`, `IncPC`, `PCin`. Next state T1.
- **T1:** `Read`, `MDRin`. Stays in T1 while `mem_wait`=1; otherwise goes to T2.
- **T2:** `MDRout`, `IRin`. Next state T3. `IR` is valid from T3 onward.
- **Three-operand ALU ops (add … shl):**
  - T3: `reg_out[rb]`, `Yin`.
  - T4: `reg_out[rc]`, `alu_op`, `Zin`.
  - T5: `Zlowout`, `reg_in[ra]`. Then T0.
- **mul/div:**
  - T3: `reg_out[ra]`, `Yin`.
  - T4: `reg_out[rb]`, `alu_op`, `Zin`.
  - T5: `Zlowout`, `LOin`.
  - T6: `Zhighout`, `HIin`. Then T0.
- **neg/not:**
  - T3: `reg_out[rb]`, `alu_op`, `Zin`.
  - T4: `Zlowout`, `reg_in[ra]`. Then T0.
- **nop:** T3 asserts no strobes, then T0.
- **halt:** T3 goes to HALT. `halted`=1. HALT is left only by `reset`; `run` is ignored there.
- **Illegal opcode:** `ill`=1 for T3 only, then T0. No register is written.
- **One-hot rules:**
  - At most one bus driver is active per cycle.
  - `reg_out` and `reg_in` are each one-hot or zero.
  - `ra`=`rb` is legal; so is R0 as a destination.

## Timing
- Outputs are a combinational decode of the registered state plus `IR`. They are valid for the whole state cycle, and the datapath captures them at the next edge.
- **Reset:** `reset`=1 at an edge puts the block in IDLE. Every output is 0 in the following cycle, including a reset that arrives mid-instruction. A partial instruction is abandoned.
- **Reset vs `run`:** `reset` has priority when both are high.
- **Latency from T0 with `mem_wait`=0:**
  - ALU ops: 6 cycles.
  - mul/div: 7 cycles.
  - neg/not: 5 cycles.
  - nop and illegal: 4 cycles.
  - Each `mem_wait` cycle adds 1.
- **`mem_wait`:** sampled only in T1. Ignored in every other state.
- **`run`:** sampled only in IDLE. Deasserting `run` mid-stream does not stop the sequence; only halt or `reset` stops it.

## Configuration
- Macro `CTRL_MULDIV_EN`.
- **Defined:** mul/div use the T3–T6 sequence above.
- **Undefined:** opcodes 01111 and 10000 are illegal (`ill` pulse, return to T0). T6 is unreachable, and `HIin`, `LOin` and `Zhighout` are tied 0.

## Structure
- `ctrl_pkg` holds:
  - opcode localparams;
  - the state encoding, 4-bit localparams;
  - `alu_op` bit indices;
  - IR field bit positions.
- One sub-module, `ctrl_decode`: combinational opcode to {class, `alu_op` one-hot, `ill`}, where class is alu3, muldiv, unary, nop, halt or illegal.
- The 4-to-16 register select is shared logic inside `control_unit`.

## Test plan
- **SUB:** reset, then `run`; at T2 feed `IR`=0x221B8000 (sub R4,R3,R7).
  - Expect T3 `R3out`+`Yin`, T4 `R7out`+`SUB`+`Zin`, T5 `Zlowout`+`R4in`.
  - Back in T0 six cycles after the first T0.
- **MUL with `CTRL_MULDIV_EN`:** `IR`=0x80980000 (mul R1,R3).
  - Expect T5 `Zlowout`+`LOin`, T6 `Zhighout`+`HIin`. 7-cycle latency.
  - Without the macro: `ill`=1 at T3, next state T0.
- **`mem_wait`:** hold `mem_wait`=1 for 3 cycles in T1 → `Read` and `MDRin` stay high 4 cycles, then T2.
- **halt:** `IR`=0xD8000000 → `halted`=1 from the cycle after T3. Holds through 10 cycles of `run` toggling.
- **Reset mid-instruction:** `reset`=1 during T4 of an add → all outputs 0 the next cycle, state IDLE. No `reg_in` pulse.
- **Illegal opcode:** `IR`=0xF8000000 → `ill` one cycle at T3. Every `reg_in` bit stays 0. T0 follows.
